// File: rtl/time_display_scan.sv
// Six-digit multiplexed 7-segment scanner for HH:MM:SS with an expiry FSM.
// Optional display blanking while expired is built in with BLINK_ON_EXPIRE_EN.
module time_display_scan #(
   parameter int SCAN_DIV  = 50000,
   parameter int BLINK_DIV = 25000000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] hours,
   input  logic [5:0] mins,
   input  logic [5:0] secs,
   input  logic       running,
   output logic [6:0] seg,
   output logic [5:0] an,
   output logic       expired
);

   // state   | meaning
   // IDLE    | countdown stopped or never started
   // ARMED   | countdown running with a nonzero time
   // EXPIRED | countdown reached 0:0:0 while armed
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      EXPIRED = 2'd2
   } state_t;

   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [5:0] AN_OFF    = 6'b111111;

   state_t            state;
   state_t            state_next;
   logic [SCAN_W-1:0] scan_cnt;
   logic [2:0]        digit_idx;
   logic [5:0]        snap_h;
   logic [5:0]        snap_m;
   logic [5:0]        snap_s;
   logic              scan_tc;
   logic              any_nonzero;
   logic              blank;
   logic [6:0]        seg_next;
   logic [5:0]        an_next;

   function automatic logic [6:0] dec_digit(input logic [5:0] d);
      logic [6:0] s;
      case (d)
         6'd0:    s = 7'b1000000;
         6'd1:    s = 7'b1111001;
         6'd2:    s = 7'b0100100;
         6'd3:    s = 7'b0110000;
         6'd4:    s = 7'b0011001;
         6'd5:    s = 7'b0010010;
         6'd6:    s = 7'b0000010;
         6'd7:    s = 7'b1111000;
         6'd8:    s = 7'b0000000;
         6'd9:    s = 7'b0010000;
         default: s = SEG_DASH;
      endcase
      return s;
   endfunction

   // Out-of-range fields (60..63) show a dash on both of their digits.
   function automatic logic [6:0] field_seg(input logic [5:0] v, input logic tens_sel);
      logic [5:0] tens;
      logic [5:0] ones;
      tens = v / 6'd10;
      ones = v % 6'd10;
      if (v > 6'd59) begin
         return SEG_DASH;
      end
      return dec_digit(tens_sel ? tens : ones);
   endfunction

   assign scan_tc     = (scan_cnt == SCAN_LAST);
   assign any_nonzero = |{hours, mins, secs};

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         scan_cnt  <= '0;
         digit_idx <= 3'd0;
      end else if (scan_tc) begin
         scan_cnt  <= '0;
         digit_idx <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
      end else begin
         scan_cnt  <= scan_cnt + SCAN_W'(1);
      end
   end

   // Snapshot only at the 5->0 wrap so one scan never mixes two times.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         snap_h <= 6'd0;
         snap_m <= 6'd0;
         snap_s <= 6'd0;
      end else if (scan_tc && digit_idx == 3'd5) begin
         snap_h <= hours;
         snap_m <= mins;
         snap_s <= secs;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // An all-zero time in ARMED expires even if running drops on the same cycle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (running && any_nonzero) begin
               state_next = ARMED;
            end
         end
         ARMED: begin
            if (!any_nonzero) begin
               state_next = EXPIRED;
            end else if (!running) begin
               state_next = IDLE;
            end
         end
         EXPIRED: begin
            if (any_nonzero) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

`ifdef BLINK_ON_EXPIRE_EN
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   logic [BLINK_W-1:0] blink_cnt;
   logic               blink_phase;

   // Counting starts the cycle after entry and clears on the exit edge.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (state != EXPIRED || state_next != EXPIRED) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt   <= blink_cnt + BLINK_W'(1);
      end
   end

   assign blank = (state == EXPIRED) && blink_phase;
`else
   // Without blinking the display never blanks; BLINK_DIV has no effect here.
   assign blank = (BLINK_DIV < 0);
`endif

   always_comb begin
      seg_next = SEG_BLANK;
      case (digit_idx)
         3'd0:    seg_next = field_seg(snap_s, 1'b0);
         3'd1:    seg_next = field_seg(snap_s, 1'b1);
         3'd2:    seg_next = field_seg(snap_m, 1'b0);
         3'd3:    seg_next = field_seg(snap_m, 1'b1);
         3'd4:    seg_next = field_seg(snap_h, 1'b0);
         3'd5:    seg_next = field_seg(snap_h, 1'b1);
         default: seg_next = SEG_BLANK;
      endcase
   end

   assign an_next = ~(6'b000001 << digit_idx);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         seg     <= SEG_BLANK;
         an      <= AN_OFF;
         expired <= 1'b0;
      end else begin
         seg     <= seg_next;
         an      <= blank ? AN_OFF : an_next;
         expired <= (state == EXPIRED);
      end
   end

endmodule
